// File: rtl/audio_sample_sched.sv
// Stereo sample scheduler: round-robin arbitration of two producers into a
// small stereo FIFO, popped once per LRCK frame onto frame-stable outputs.
module audio_sample_sched #(
  parameter int DEPTH         = 4,
  parameter int LVL_W         = 3,
  parameter bit UNDERRUN_ZERO = 1'b1
) (
  input  logic             CLK_18_4,
  input  logic             RST_N,
  input  logic             AUD_LRCK,
  input  logic             mute,
  input  logic             req0_valid,
  input  logic [15:0]      req0_left,
  input  logic [15:0]      req0_right,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [15:0]      req1_left,
  input  logic [15:0]      req1_right,
  output logic             req1_ready,
  output logic [15:0]      left_sample,
  output logic [15:0]      right_sample,
  output logic [LVL_W-1:0] fifo_level,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             lrck_d_r;
  logic             last_grant_r;

  logic             full_s;
  logic             empty_s;
  logic             strobe_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      push_data_s;
  logic [31:0]      head_s;

  assign full_s   = (fifo_level == LVL_W'(DEPTH));
  assign empty_s  = (fifo_level == {LVL_W{1'b0}});
  assign strobe_s = lrck_d_r & ~AUD_LRCK;
  assign pop_s    = strobe_s & ~empty_s;
  assign head_s   = mem_r[rd_ptr_r];

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    push_data_s = 32'd0;
    if (req0_valid && (!req1_valid || last_grant_r)) begin
      grant0_s    = 1'b1;
      push_data_s = {req0_left, req0_right};
    end else if (req1_valid) begin
      grant1_s    = 1'b1;
      push_data_s = {req1_left, req1_right};
    end else begin
      grant0_s    = 1'b0;
      grant1_s    = 1'b0;
    end
  end

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign req0_ready = RST_N & grant0_s & ~full_s;
  assign req1_ready = RST_N & grant1_s & ~full_s;
  assign push_s     = req0_ready | req1_ready;

  // LRCK edge detector and arbitration history.
  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      lrck_d_r     <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      lrck_d_r <= AUD_LRCK;
      if (req0_ready) begin
        last_grant_r <= 1'b0;
      end else if (req1_ready) begin
        last_grant_r <= 1'b1;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_level <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Frame outputs move only on strobe cycles so they stay constant for a whole frame.
  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      left_sample  <= 16'd0;
      right_sample <= 16'd0;
    end else if (pop_s) begin
      if (mute) begin
        left_sample  <= 16'd0;
        right_sample <= 16'd0;
      end else begin
        left_sample  <= head_s[31:16];
        right_sample <= head_s[15:0];
      end
    end else if (strobe_s && (UNDERRUN_ZERO || mute)) begin
      left_sample  <= 16'd0;
      right_sample <= 16'd0;
    end
  end

  // Underrun pulse and saturating count.
  always_ff @(posedge CLK_18_4 or negedge RST_N) begin
    if (!RST_N) begin
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      underrun <= strobe_s & empty_s;
      if (strobe_s && empty_s && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_sched.sv
// Bench for audio_sample_sched: two instances (zero / hold on underrun) share
// stimulus and are compared each cycle against a queue-based frame model.
module tb_audio_sample_sched;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrck = 1'b0;
  logic        mute = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] l0 = 16'd0, r0 = 16'd0, l1 = 16'd0, r1 = 16'd0;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic [15:0] lo [2];
  logic [15:0] ro [2];
  logic [LVL_W-1:0] lvl [2];
  logic        und [2];
  logic [7:0]  ucnt [2];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  audio_sample_sched #(.DEPTH(DEPTH), .LVL_W(LVL_W), .UNDERRUN_ZERO(1'b1)) u_zero (
    .CLK_18_4(clk), .RST_N(rst_n), .AUD_LRCK(lrck), .mute(mute),
    .req0_valid(v0), .req0_left(l0), .req0_right(r0), .req0_ready(rdy0[0]),
    .req1_valid(v1), .req1_left(l1), .req1_right(r1), .req1_ready(rdy1[0]),
    .left_sample(lo[0]), .right_sample(ro[0]), .fifo_level(lvl[0]),
    .underrun(und[0]), .underrun_cnt(ucnt[0]));

  audio_sample_sched #(.DEPTH(DEPTH), .LVL_W(LVL_W), .UNDERRUN_ZERO(1'b0)) u_hold (
    .CLK_18_4(clk), .RST_N(rst_n), .AUD_LRCK(lrck), .mute(mute),
    .req0_valid(v0), .req0_left(l0), .req0_right(r0), .req0_ready(rdy0[1]),
    .req1_valid(v1), .req1_left(l1), .req1_right(r1), .req1_ready(rdy1[1]),
    .left_sample(lo[1]), .right_sample(ro[1]), .fifo_level(lvl[1]),
    .underrun(und[1]), .underrun_cnt(ucnt[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of frames plus who was served last.
  logic [31:0] q [$];
  bit          m_last;
  bit          m_lrck_prev;
  logic [15:0] m_l [2];
  logic [15:0] m_r [2];
  bit          m_und;
  int          m_cnt;
  logic [31:0] m_f;
  bit          m_take0, m_take1, m_frame_start;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = 1'b1; m_lrck_prev = 1'b0; m_und = 1'b0; m_cnt = 0;
      for (int k = 0; k < 2; k++) begin m_l[k] = 16'd0; m_r[k] = 16'd0; end
    end else begin
      m_frame_start = m_lrck_prev && !lrck;
      m_take0 = v0 && (!v1 || m_last) && (q.size() < DEPTH);
      m_take1 = v1 && !m_take0 && (q.size() < DEPTH);
      m_und = 1'b0;
      if (m_frame_start) begin
        if (q.size() > 0) begin
          m_f = q.pop_front();
          for (int k = 0; k < 2; k++) begin
            m_l[k] = mute ? 16'd0 : m_f[31:16];
            m_r[k] = mute ? 16'd0 : m_f[15:0];
          end
        end else begin
          m_und = 1'b1;
          if (m_cnt < 255) m_cnt++;
          m_l[0] = 16'd0; m_r[0] = 16'd0;
          if (mute) begin m_l[1] = 16'd0; m_r[1] = 16'd0; end
        end
      end
      if (m_take0) begin q.push_back({l0, r0}); m_last = 1'b0; end
      if (m_take1) begin q.push_back({l1, r1}); m_last = 1'b1; end
      m_lrck_prev = lrck;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check("left", 32'(lo[k]), 32'(m_l[k]));
        check("right", 32'(ro[k]), 32'(m_r[k]));
        check("level", 32'(lvl[k]), 32'(q.size()));
        check("underrun", 32'(und[k]), 32'(m_und));
        check("underrun_cnt", 32'(ucnt[k]), 32'(m_cnt));
        check("ready0", 32'(rdy0[k]),
              32'(rst_n && v0 && (!v1 || m_last) && (q.size() < DEPTH)));
        check("ready1", 32'(rdy1[k]),
              32'(rst_n && v1 && !(v0 && (!v1 || m_last)) && (q.size() < DEPTH)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; mute = 1'b0; lrck = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One LRCK period compressed to two clocks; returns just after the strobe edge.
  task automatic strobe_frame();
    lrck = 1'b1;
    tick();
    lrck = 1'b0;
    tick();
  endtask

  task automatic push0(input logic [15:0] l, input logic [15:0] r);
    bit done;
    done = 1'b0;
    v0 = 1'b1; l0 = l; r0 = r;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (rdy0[0]) done = 1'b1;
      tick();
    end
    if (!done) check("push0_timeout", 32'd0, 32'd1);
    v0 = 1'b0;
  endtask

  initial begin
    bit a0, a1;
    int k0, k1;

    // Reset state
    do_reset();
    cmp_en = 1'b1;
    check("rst_left", 32'(lo[0]), 32'h0);
    check("rst_level", 32'(lvl[0]), 32'h0);
    check("rst_cnt", 32'(ucnt[0]), 32'h0);

    // Test 1: single push then frame pop
    push0(16'h1234, 16'hABCD);
    check("t1_level_before", 32'(lvl[0]), 32'd1);
    strobe_frame();
    check("t1_left", 32'(lo[0]), 32'h1234);
    check("t1_right", 32'(ro[0]), 32'hABCD);
    check("t1_level_after", 32'(lvl[0]), 32'd0);
    check("t1_underrun", 32'(und[0]), 32'd0);

    // Test 2: both producers continuously valid, fill to full
    do_reset();
    k0 = 0; k1 = 0;
    l0 = 16'h0001; r0 = 16'h0101; l1 = 16'h8001; r1 = 16'h8101;
    v0 = 1'b1; v1 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      a0 = rdy0[0]; a1 = rdy1[0];
      tick();
      if (a0) begin k0++; l0 = 16'h0001 + 16'(k0); r0 = 16'h0101 + 16'(k0); end
      if (a1) begin k1++; l1 = 16'h8001 + 16'(k1); r1 = 16'h8101 + 16'(k1); end
    end
    check("t2_level_full", 32'(lvl[0]), 32'd4);
    check("t2_ready0_low", 32'(rdy0[0]), 32'd0);
    check("t2_ready1_low", 32'(rdy1[0]), 32'd0);

    // Test 4: full + strobe with only req0 valid
    v1 = 1'b0;
    lrck = 1'b0;
    @(negedge clk);
    check("t4_ready0_blocked", 32'(rdy0[0]), 32'd0);
    tick();
    check("t4_first_left", 32'(lo[0]), 32'h0001);
    check("t4_first_right", 32'(ro[0]), 32'h0101);
    check("t4_level3", 32'(lvl[0]), 32'd3);
    check("t4_ready0_now", 32'(rdy0[0]), 32'd1);
    tick();
    v0 = 1'b0;
    check("t4_level4", 32'(lvl[0]), 32'd4);
    strobe_frame();
    check("t2_second_left", 32'(lo[0]), 32'h8001);
    strobe_frame();
    check("t2_third_left", 32'(lo[0]), 32'h0002);

    // Test 3: underrun zero vs hold
    do_reset();
    push0(16'h5555, 16'h6666);
    strobe_frame();
    check("t3_loaded", 32'(lo[1]), 32'h5555);
    for (int n = 0; n < 3; n++) begin
      strobe_frame();
      check("t3_pulse", 32'(und[0]), 32'd1);
    end
    check("t3_cnt", 32'(ucnt[0]), 32'd3);
    check("t3_zero_left", 32'(lo[0]), 32'h0);
    check("t3_hold_left", 32'(lo[1]), 32'h5555);
    check("t3_hold_right", 32'(ro[1]), 32'h6666);

    // Test 5: mute with queued frames, then counter saturation
    do_reset();
    push0(16'h1111, 16'h2222);
    push0(16'h3333, 16'h4444);
    mute = 1'b1;
    strobe_frame();
    check("t5_mute_left", 32'(lo[1]), 32'h0);
    check("t5_no_underrun", 32'(und[0]), 32'd0);
    strobe_frame();
    check("t5_level0", 32'(lvl[0]), 32'd0);
    check("t5_cnt0", 32'(ucnt[0]), 32'd0);
    for (int n = 0; n < 300; n++) strobe_frame();
    check("t5_cnt_sat", 32'(ucnt[0]), 32'd255);
    check("t5_cnt_sat_hold", 32'(ucnt[1]), 32'd255);
    mute = 1'b0;

    // Test 6: reset mid-transfer with 3 frames queued
    do_reset();
    strobe_frame();
    for (int n = 0; n < 4; n++) push0(16'hA000 + 16'(n), 16'hB000 + 16'(n));
    strobe_frame();
    check("t6_pre_level", 32'(lvl[0]), 32'd3);
    check("t6_pre_left", 32'(lo[0]), 32'hA000);
    v0 = 1'b1; l0 = 16'hCCCC; r0 = 16'hDDDD;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_left", 32'(lo[0]), 32'h0);
    check("t6_rst_level", 32'(lvl[0]), 32'h0);
    check("t6_rst_cnt", 32'(ucnt[0]), 32'h0);
    check("t6_rst_ready", 32'(rdy0[0]), 32'h0);
    v0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    strobe_frame();
    check("t6_underrun", 32'(und[0]), 32'd1);
    check("t6_cnt1", 32'(ucnt[0]), 32'd1);

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
